// File: rtl/zclock_pkg.sv
// Shared speed codes and helpers for the Z80 clock generator.
package zclock_pkg;

    localparam int unsigned SPD_14  = 0;
    localparam int unsigned SPD_7   = 1;
    localparam int unsigned SPD_35  = 2;
    localparam int unsigned SPD_175 = 3;

    // Phase bits that must all be ones before a strobe may fire at speed s.
    function automatic int unsigned spd_mask(input int unsigned s);
        return (32'd1 << s) - 32'd1;
    endfunction

endpackage

// File: rtl/zclock_gen_if.sv
// Bus between the core arbiter (master) and the clock generator (slave).
interface zclock_gen_if #(
    parameter int unsigned SPD_W  = 2,
    parameter int unsigned N_WAIT = 2,
    parameter int unsigned WAIT_W = 4
) ();

    logic [SPD_W-1:0]         speed_req;
    logic                     rfsh;
    logic                     stall_in;
    logic [N_WAIT-1:0]        wait_trig;
    logic [N_WAIT*WAIT_W-1:0] wait_len;
    logic [N_WAIT-1:0]        wait_fast_only;

    logic                     zclk_out;
    logic                     zpos;
    logic                     zneg;
    logic [SPD_W-1:0]         speed_cur;
    logic [N_WAIT-1:0]        wait_busy;

    modport master (
        output speed_req, rfsh, stall_in, wait_trig, wait_len, wait_fast_only,
        input  zclk_out, zpos, zneg, speed_cur, wait_busy
    );

    modport slave (
        input  speed_req, rfsh, stall_in, wait_trig, wait_len, wait_fast_only,
        output zclk_out, zpos, zneg, speed_cur, wait_busy
    );

endinterface

// File: rtl/zclock_wait_ch.sv
// One retriggerable wait-state channel: a trigger loads the length, then counts down to zero.
module zclock_wait_ch #(
    parameter int unsigned WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig_i,
    input  logic [WAIT_W-1:0] len_i,
    input  logic              fast_only_i,
    input  logic              spd_fast_i,
    output logic              accept_o,
    output logic              busy_o
);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    // Fast-only channels ignore triggers unless running at the top speed.
    always_comb begin
        accept_o = trig_i & (~fast_only_i | spd_fast_i);
    end

    // Reload on an accepted trigger (no accumulation), otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_o) begin
            cnt_d = len_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/zclock_gen.sv
// Z80 clock generator: divides clk into zclk_out with zpos/zneg pre-edge strobes, applies
// speed changes only at a safe zpos, and stalls on wait channels or an external stall level.
module zclock_gen
    import zclock_pkg::*;
#(
    parameter int unsigned SPD_W          = 2,
    parameter int unsigned INIT_SPEED     = 2,
    parameter int unsigned N_WAIT         = 2,
    parameter int unsigned WAIT_W         = 4,
    parameter bit          SWITCH_ANYTIME = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    zclock_gen_if.slave bus
);

    // Highest usable speed code; the phase counter needs one bit per doubling.
    localparam int unsigned SPD_MAX = ((2 ** SPD_W) - 1 > SPD_175) ? SPD_175 : (2 ** SPD_W) - 1;
    localparam int unsigned PH_W    = (SPD_MAX > 0) ? SPD_MAX : 1;

    logic [PH_W-1:0]   ph_q, ph_d;
    logic [PH_W-1:0]   mask;
    logic [SPD_W-1:0]  speed_q, speed_d, speed_tgt;
    logic              zpos_q, zpos_d, zneg_q, zneg_d, zclk_q;
    logic [N_WAIT-1:0] accept, busy;
    logic              stall, tick, do_switch;

    generate
        if ((2 ** SPD_W) - 1 > SPD_MAX) begin : g_clamp
            // Codes beyond the slowest supported speed run at the slowest speed.
            always_comb begin
                speed_tgt = (bus.speed_req > SPD_W'(SPD_MAX)) ? SPD_W'(SPD_MAX) : bus.speed_req;
            end
        end else begin : g_noclamp
            assign speed_tgt = bus.speed_req;
        end
    endgenerate

    for (genvar i = 0; i < N_WAIT; i++) begin : g_wait
        zclock_wait_ch #(
            .WAIT_W (WAIT_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .trig_i      (bus.wait_trig[i]),
            .len_i       (bus.wait_len[i*WAIT_W +: WAIT_W]),
            .fast_only_i (bus.wait_fast_only[i]),
            .spd_fast_i  (speed_q == '0),
            .accept_o    (accept[i]),
            .busy_o      (busy[i])
        );
    end

    // Tick, strobe and speed-switch decisions; a switch restarts the phase so the
    // new rate begins with a full low half-period.
    always_comb begin
        mask      = PH_W'(spd_mask(32'(speed_q)));
        tick      = ((ph_q & mask) == mask);
        stall     = bus.stall_in | (|busy) | (|accept);
        zpos_d    = tick & ~stall & zclk_q;
        zneg_d    = tick & ~stall & ~zclk_q;
        do_switch = (speed_tgt != speed_q) & zpos_d & (bus.rfsh | SWITCH_ANYTIME);
        speed_d   = do_switch ? speed_tgt : speed_q;
        if (do_switch) begin
            ph_d = '0;
        end else if (stall) begin
            ph_d = ph_q;
        end else begin
            ph_d = ph_q + PH_W'(1);
        end
    end

    // Phase, speed and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q    <= '0;
            speed_q <= SPD_W'(INIT_SPEED);
            zpos_q  <= 1'b0;
            zneg_q  <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            speed_q <= speed_d;
            zpos_q  <= zpos_d;
            zneg_q  <= zneg_d;
        end
    end

    // zclk edges move half a clk after the strobes so the core sees them early.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zclk_q <= 1'b0;
        end else if (zpos_q) begin
            zclk_q <= 1'b0;
        end else if (zneg_q) begin
            zclk_q <= 1'b1;
        end
    end

    assign bus.zclk_out  = zclk_q;
    assign bus.zpos      = zpos_q;
    assign bus.zneg      = zneg_q;
    assign bus.speed_cur = speed_q;
    assign bus.wait_busy = busy;

endmodule
